// File: rtl/conv_stream_ctrl_pkg.sv
// Shared defaults, lane count and run-state encoding for the convolution stream controller.
package conv_pkg;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MAX_IMG = 9;
   localparam int unsigned MAX_KER = 3;
   localparam int unsigned DIM_W   = $clog2(MAX_IMG + 1);
   localparam int unsigned LANES   = MAX_KER * MAX_KER;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_stream_ctrl_lane_skew.sv
// Per-lane delay chain: DEPTH stages of {valid,data}, advancing only while en is high.
module lane_skew #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);
   localparam int unsigned SW = DATA_W + 1;

   if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
   end else if (DEPTH == 1) begin : g_one
      logic [SW-1:0] sr;
      always_ff @(posedge clk) begin
         if (reset)   sr <= '0;
         else if (en) sr <= {in_valid, in_data};
      end
      assign {out_valid, out_data} = sr;
   end else begin : g_chain
      // newest entry in the low slot, oldest in the high slot
      logic [DEPTH*SW-1:0] sr;
      always_ff @(posedge clk) begin
         if (reset)   sr <= '0;
         else if (en) sr <= {sr[(DEPTH-1)*SW-1:0], in_valid, in_data};
      end
      assign {out_valid, out_data} = sr[DEPTH*SW-1 -: SW];
   end
endmodule

// File: rtl/conv_stream_ctrl.sv
// Buffers an image and kernel, then streams every sliding-window patch im2col style
// over skewed lanes, with static kernel lanes, backpressure and config checking.
module conv_stream_ctrl #(
   parameter int unsigned DATA_W  = conv_pkg::DATA_W,
   parameter int unsigned MAX_IMG = conv_pkg::MAX_IMG,
   parameter int unsigned MAX_KER = conv_pkg::MAX_KER,
   parameter int unsigned DIM_W   = $clog2(MAX_IMG + 1)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [DATA_W-1:0]                   wr_data,
   input  logic                                img_we,
   input  logic                                ker_we,
   input  logic [DIM_W-1:0]                    img_h,
   input  logic [DIM_W-1:0]                    img_w,
   input  logic [DIM_W-1:0]                    ker_h,
   input  logic [DIM_W-1:0]                    ker_w,
   input  logic                                start,
   input  logic                                out_ready,
   output logic [MAX_KER*MAX_KER*DATA_W-1:0]   act_lanes,
   output logic [MAX_KER*MAX_KER-1:0]          lane_valid,
   output logic [MAX_KER*MAX_KER*DATA_W-1:0]   ker_lanes,
   output logic                                busy,
   output logic                                done,
   output logic                                cfg_err
);
   import conv_pkg::*;

   localparam int unsigned NLANES = MAX_KER * MAX_KER;
   localparam int unsigned IMG_N  = MAX_IMG * MAX_IMG;
   localparam int unsigned IMG_AW = $clog2(IMG_N);
   localparam int unsigned KER_AW = $clog2(NLANES);
   localparam int unsigned KW     = $clog2(NLANES + 1);
   localparam logic [DIM_W-1:0] IMG_LIM = DIM_W'(MAX_IMG);
   localparam logic [DIM_W-1:0] KER_LIM = DIM_W'(MAX_KER);

   state_t             state;
   logic [DATA_W-1:0]  img_mem [IMG_N];
   logic [DATA_W-1:0]  ker_mem [NLANES];
   logic [DATA_W-1:0]  ker_q [NLANES];
   logic [DATA_W-1:0]  ker_next [NLANES];
   logic [DATA_W-1:0]  issue_data [NLANES];
   logic               issue_valid [NLANES];
   logic [DIM_W-1:0]   img_row, img_col, ker_row, ker_col;
   logic [DIM_W-1:0]   cfg_kw, oh, ow, oy, ox;
   logic [DIM_W-1:0]   ir, ic, kr, kc;
   logic [KW-1:0]      kk, kk_in, dcnt;
   logic               cfg_bad, img_wr, ker_wr, img_wrap, ker_wrap, cfg_err_r;

   assign img_wr   = img_we && (state == IDLE) && (img_row < IMG_LIM);
   assign ker_wr   = ker_we && (state == IDLE) && (ker_row < KER_LIM);
   assign img_wrap = (img_col + 1'b1 >= img_w) || (img_col + 1'b1 >= IMG_LIM);
   assign ker_wrap = (ker_col + 1'b1 >= ker_w) || (ker_col + 1'b1 >= KER_LIM);
   assign kk_in    = KW'(ker_h * ker_w);

   always_comb begin
      cfg_bad = (ker_h == '0) || (ker_w == '0) || (ker_h > img_h) || (ker_w > img_w) ||
                (img_h > IMG_LIM) || (img_w > IMG_LIM) || (ker_h > KER_LIM) || (ker_w > KER_LIM);
   end

   // Lane k maps to (row, col) = (k / width, k % width); walk it incrementally instead of dividing.
   always_comb begin
      kr = '0;
      kc = '0;
      for (int unsigned k = 0; k < NLANES; k++) begin
         ker_next[KER_AW'(k)] = '0;
         if (KW'(k) < kk_in)
            ker_next[KER_AW'(k)] = ker_mem[KER_AW'(kr * MAX_KER + kc)];
         if (kc + 1'b1 == ker_w) begin
            kc = '0;
            kr = kr + 1'b1;
         end else begin
            kc = kc + 1'b1;
         end
      end
   end

   always_comb begin
      ir = '0;
      ic = '0;
      for (int unsigned k = 0; k < NLANES; k++) begin
         issue_valid[KER_AW'(k)] = 1'b0;
         issue_data[KER_AW'(k)]  = '0;
         if (state == RUN && KW'(k) < kk) begin
            issue_valid[KER_AW'(k)] = 1'b1;
            issue_data[KER_AW'(k)]  = img_mem[IMG_AW'((oy + ir) * MAX_IMG + ox + ic)];
         end
         if (ic + 1'b1 == cfg_kw) begin
            ic = '0;
            ir = ir + 1'b1;
         end else begin
            ic = ic + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && img_wr) img_mem[IMG_AW'(img_row * MAX_IMG + img_col)] <= wr_data;
      if (!reset && ker_wr) ker_mem[KER_AW'(ker_row * MAX_KER + ker_col)] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cfg_err_r <= 1'b0;
         img_row   <= '0;
         img_col   <= '0;
         ker_row   <= '0;
         ker_col   <= '0;
         cfg_kw    <= '0;
         oh        <= '0;
         ow        <= '0;
         oy        <= '0;
         ox        <= '0;
         kk        <= '0;
         dcnt      <= '0;
         ker_q     <= '{default: '0};
      end else begin
         cfg_err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (img_wr) begin
                  if (img_wrap) begin
                     img_col <= '0;
                     img_row <= img_row + 1'b1;
                  end else begin
                     img_col <= img_col + 1'b1;
                  end
               end
               if (ker_wr) begin
                  if (ker_wrap) begin
                     ker_col <= '0;
                     ker_row <= ker_row + 1'b1;
                  end else begin
                     ker_col <= ker_col + 1'b1;
                  end
               end
               if (start) begin
                  if (cfg_bad) begin
                     cfg_err_r <= 1'b1;
                  end else begin
                     state  <= RUN;
                     cfg_kw <= ker_w;
                     oh     <= img_h - ker_h + 1'b1;
                     ow     <= img_w - ker_w + 1'b1;
                     kk     <= kk_in;
                     oy     <= '0;
                     ox     <= '0;
                     ker_q  <= ker_next;
                  end
               end
            end
            RUN: if (out_ready) begin
               if (ox == ow - 1'b1) begin
                  ox <= '0;
                  if (oy == oh - 1'b1) begin
                     dcnt  <= '0;
                     state <= (kk == KW'(1)) ? DONE : DRAIN;
                  end else begin
                     oy <= oy + 1'b1;
                  end
               end else begin
                  ox <= ox + 1'b1;
               end
            end
            // KK-1 extra cycles let the deepest lane emit the final patch
            DRAIN: if (out_ready) begin
               if (dcnt == kk - KW'(2)) state <= DONE;
               else                     dcnt  <= dcnt + 1'b1;
            end
            DONE: if (out_ready) begin
               state   <= IDLE;
               img_row <= '0;
               img_col <= '0;
               ker_row <= '0;
               ker_col <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE) && out_ready;
   assign cfg_err = cfg_err_r;

   for (genvar k = 0; k < NLANES; k++) begin : g_lane
      lane_skew #(
         .DATA_W (DATA_W),
         .DEPTH  (k)
      ) u_skew (
         .clk       (clk),
         .reset     (reset),
         .en        (out_ready),
         .in_valid  (issue_valid[k]),
         .in_data   (issue_data[k]),
         .out_valid (lane_valid[k]),
         .out_data  (act_lanes[k*DATA_W +: DATA_W])
      );
      assign ker_lanes[k*DATA_W +: DATA_W] = ker_q[k];
   end
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed and randomized bench for conv_stream_ctrl against a cycle-indexed patch model.
module tb_conv_stream_ctrl;
   localparam int DW = 32;
   localparam int MI = 9;
   localparam int MK = 3;
   localparam int NL = MK * MK;

   logic            clk = 1'b0;
   logic            reset, start, out_ready, img_we, ker_we;
   logic [DW-1:0]   wr_data;
   logic [3:0]      img_h, img_w, ker_h, ker_w;
   logic [NL*DW-1:0] act_lanes, ker_lanes;
   logic [NL-1:0]   lane_valid;
   logic            busy, done, cfg_err;

   conv_stream_ctrl #(
      .DATA_W  (DW),
      .MAX_IMG (MI),
      .MAX_KER (MK),
      .DIM_W   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_data    (wr_data),
      .img_we     (img_we),
      .ker_we     (ker_we),
      .img_h      (img_h),
      .img_w      (img_w),
      .ker_h      (ker_h),
      .ker_w      (ker_w),
      .start      (start),
      .out_ready  (out_ready),
      .act_lanes  (act_lanes),
      .lane_valid (lane_valid),
      .ker_lanes  (ker_lanes),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int unsigned img_m [MI][MI];
   int unsigned ker_m [MK][MK];
   int unsigned kexp [NL];
   int          ip_r, ip_c, kp_r, kp_c;
   bit          active, err_pend;
   int          e, m_n, m_kk, m_ow, m_kw;
   int          cyc, done_at;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // e counts non-stalled cycles since the accepted start: lane k shows patch e-1-k.
   task automatic step(input bit st, input bit rdy, input bit iwe, input bit kwe,
                       input bit rst, input logic [DW-1:0] d);
      bit            v;
      int            p, ih, iw, kh, kw;
      logic [DW-1:0] ev;
      @(negedge clk);
      start = st; out_ready = rdy; img_we = iwe; ker_we = kwe; reset = rst; wr_data = d;
      #1;
      chk("busy", busy, active);
      chk("done", done, active && (e == m_n + m_kk) && rdy);
      chk("cfg_err", cfg_err, err_pend);
      for (int k = 0; k < NL; k++) begin
         p  = e - 1 - k;
         v  = active && (k < m_kk) && (p >= 0) && (p < m_n);
         ev = v ? DW'(img_m[p / m_ow + k / m_kw][p % m_ow + k % m_kw]) : '0;
         chk($sformatf("lane%0d_valid", k), lane_valid[k], v);
         chk($sformatf("lane%0d_data", k), act_lanes[k*DW +: DW], ev);
         chk($sformatf("ker_lane%0d", k), ker_lanes[k*DW +: DW], kexp[k]);
      end
      if (rst) begin
         active = 0; err_pend = 0; e = 0;
         ip_r = 0; ip_c = 0; kp_r = 0; kp_c = 0;
         for (int k = 0; k < NL; k++) kexp[k] = 0;
      end else begin
         err_pend = 0;
         if (!active) begin
            if (st) begin
               ih = int'(img_h); iw = int'(img_w); kh = int'(ker_h); kw = int'(ker_w);
               if (kh == 0 || kw == 0 || kh > ih || kw > iw || ih > MI || iw > MI || kh > MK || kw > MK) begin
                  err_pend = 1;
               end else begin
                  active = 1; e = 1;
                  m_ow = iw - kw + 1;
                  m_n  = (ih - kh + 1) * m_ow;
                  m_kk = kh * kw;
                  m_kw = kw;
                  for (int k = 0; k < NL; k++) kexp[k] = (k < m_kk) ? ker_m[k / kw][k % kw] : 0;
               end
            end
            if (iwe && ip_r < MI) begin
               img_m[ip_r][ip_c] = d;
               ip_c++;
               if (ip_c >= int'(img_w) || ip_c >= MI) begin ip_c = 0; ip_r++; end
            end
            if (kwe && kp_r < MK) begin
               ker_m[kp_r][kp_c] = d;
               kp_c++;
               if (kp_c >= int'(ker_w) || kp_c >= MK) begin kp_c = 0; kp_r++; end
            end
         end else if (rdy) begin
            if (e == m_n + m_kk) begin
               active = 0;
               ip_r = 0; ip_c = 0; kp_r = 0; kp_c = 0;
            end else begin
               e++;
            end
         end
      end
   endtask

   task automatic load_img(input int h, input int w, input bit seq);
      img_h = 4'(h); img_w = 4'(w);
      for (int i = 0; i < h * w; i++) step(0, 1, 1, 0, 0, seq ? DW'(i + 1) : DW'($urandom));
   endtask

   task automatic load_ker(input int h, input int w, input bit seq);
      ker_h = 4'(h); ker_w = 4'(w);
      for (int i = 0; i < h * w; i++) step(0, 1, 0, 1, 0, seq ? DW'((i + 1) * 10) : DW'($urandom));
   endtask

   // exp_done < 0 skips the absolute done-cycle check (random stalls)
   task automatic run(input int exp_done, input int stall_at, input int stall_len, input bit rnd);
      bit rdy;
      done_at = -1;
      step(1, 1, 0, 0, 0, '0);
      cyc = 0;
      while (active && cyc < 400) begin
         cyc++;
         rdy = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_at && cyc < stall_at + stall_len);
         step(0, rdy, 0, 0, 0, '0);
         if (done === 1'b1) done_at = cyc;
      end
      chk("run_timeout", active, 1'b0);
      if (exp_done >= 0) chk("done_cycle", 64'(done_at), 64'(exp_done));
      step(0, 1, 0, 0, 0, '0);
   endtask

   initial begin
      int ih, iw, kh, kw;
      reset = 1'b1; start = 1'b0; out_ready = 1'b1; img_we = 1'b0; ker_we = 1'b0; wr_data = '0;
      img_h = '0; img_w = '0; ker_h = '0; ker_w = '0;
      active = 0; err_pend = 0; e = 0; m_n = 0; m_kk = 0; m_ow = 1; m_kw = 1;
      ip_r = 0; ip_c = 0; kp_r = 0; kp_c = 0;
      for (int k = 0; k < NL; k++) kexp[k] = 0;

      step(0, 1, 0, 0, 1, '0);
      step(0, 1, 0, 0, 1, '0);

      // 3x3 image 1..9, 2x2 kernel 10..40
      load_img(3, 3, 1);
      load_ker(2, 2, 1);
      run(8, 0, 0, 0);

      // 2x2 image, 1x1 kernel
      load_img(2, 2, 1);
      load_ker(1, 1, 1);
      run(5, 0, 0, 0);

      // full-size 9x9 image with 3x3 kernel
      load_img(9, 9, 0);
      load_ker(3, 3, 0);
      run(58, 0, 0, 0);

      // rejected configurations, then a valid run on the same buffers
      img_h = 4'd3; img_w = 4'd3; ker_h = 4'd4; ker_w = 4'd4;
      run(-1, 0, 0, 0);
      ker_h = 4'd0; ker_w = 4'd2;
      run(-1, 0, 0, 0);
      img_h = 4'd10; ker_h = 4'd2;
      run(-1, 0, 0, 0);
      img_h = 4'd3; img_w = 4'd1;
      run(-1, 0, 0, 0);
      img_w = 4'd3;
      run(8, 0, 0, 0);

      // three-cycle stall starting at T+3
      load_img(3, 3, 1);
      load_ker(2, 2, 1);
      run(11, 3, 3, 0);

      // reset in T+3 of a run, then a fresh load and run
      step(1, 1, 0, 0, 0, '0);
      step(0, 1, 0, 0, 0, '0);
      step(0, 1, 0, 0, 0, '0);
      step(0, 1, 0, 0, 1, '0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, '0);
      load_img(3, 3, 0);
      load_ker(2, 2, 0);
      run(8, 0, 0, 0);

      // random shapes, data and backpressure
      for (int t = 0; t < 6; t++) begin
         ih = $urandom_range(1, MI);
         iw = $urandom_range(1, MI);
         kh = $urandom_range(1, (ih < MK) ? ih : MK);
         kw = $urandom_range(1, (iw < MK) ? iw : MK);
         load_img(ih, iw, 0);
         load_ker(kh, kw, 0);
         run(-1, 0, 0, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
